fxp_square_seq: RTL



---
 rtl/fxp_square_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fxp_square_seq.sv
// Multi-cycle fixed-point squarer: |x| squared by a one-bit-per-cycle shift-add multiplier,
// then rescaled with optional rounding and saturation. FXP_SQUARE_SEQ_EARLY_EXIT_EN enables early CALC exit.
module fxp_square_seq #(
    parameter int unsigned WII   = 8,
    parameter int unsigned WIF   = 8,
    parameter int unsigned WOI   = 16,
    parameter int unsigned WOF   = 8,
    parameter int unsigned ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [WII+WIF-1:0]   in,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 overflow
);

    localparam int unsigned N   = WII + WIF;
    localparam int unsigned NO  = WOI + WOF;
    localparam int unsigned FD  = 2 * WIF;
    localparam int unsigned LS  = (WOF > FD) ? WOF - FD : 0;
    localparam int unsigned SWA = 2 * N + LS + 1;
    // Scaled width covers both the shifted square and the saturation limit.
    localparam int unsigned SW  = (SWA > NO + 1) ? SWA : NO + 1;
    localparam int unsigned CW  = $clog2(N + 1);

    localparam logic [SW-1:0] MaxOut = (SW'(1) << (NO - 1)) - SW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDoneLoad,
        StOut
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NO-1:0]   out_q, out_d;
    logic            ovf_q, ovf_d;

    logic [N-1:0]    mag;
    logic            calc_last;
    logic [SW-1:0]   scaled;
    logic            sat_ovf;
    logic [NO-1:0]   sat_val;

    // Two's-complement negation of the most negative input yields 2^(N-1) as unsigned.
    assign mag = in[N-1] ? (~in + N'(1)) : in;

`ifdef FXP_SQUARE_SEQ_EARLY_EXIT_EN
    assign calc_last = (cnt_q == CW'(N - 1)) || ((mplier_q >> 1) == '0);
`else
    assign calc_last = (cnt_q == CW'(N - 1));
`endif

    generate
        if (WOF < FD) begin : g_drop
            localparam int unsigned D = FD - WOF;
            logic [SW-1:0] rnd;
            assign rnd    = (ROUND != 0) ? SW'(acc_q[D-1]) : '0;
            assign scaled = (SW'(acc_q) >> D) + rnd;
        end else begin : g_shift
            assign scaled = SW'(acc_q) << LS;
        end
    endgenerate

    assign sat_ovf = (scaled > MaxOut);
    assign sat_val = sat_ovf ? MaxOut[NO-1:0] : scaled[NO-1:0];

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    mcand_d  = mag;
                    mplier_d = mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + ({{N{1'b0}}, mcand_q} << cnt_q);
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (calc_last) begin
                    state_d = StDoneLoad;
                end
            end
            StDoneLoad: begin
                out_d   = sat_val;
                ovf_d   = sat_ovf;
                state_d = StOut;
            end
            StOut: begin
                if (o_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
        end
    end

    // i_ready is gated by rstn so it reads low for the whole reset window.
    assign i_ready  = (state_q == StIdle) && rstn;
    assign o_valid  = (state_q == StOut);
    assign out      = out_q;
    assign overflow = ovf_q;

endmodule
